// File: rtl/iic_pkg.sv
// Shared definitions for the I2C register slave: FSM state encoding,
// bus ACK/NACK levels, default device address and the write-strobe payload.
// Optional feature macro: IIC_SLAVE_READ_EN (adds the RDATA/RDATA_ACK states).
package iic_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_DEPTH = 256;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h5D;

  // SDA levels as seen on the bus
  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK
`ifdef IIC_SLAVE_READ_EN
    ,
    ST_RDATA,
    ST_RDATA_ACK
`endif
  } iic_state_e;

  // Register-file write strobe payload
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

endpackage

// File: rtl/iic_slave_regs_if.sv
// I2C pad bundle between the bus side (master modport) and the slave.
//   iic_scl    : bus clock level
//   iic_sda_i  : bus data level
//   iic_sda_oe : 1 = slave pulls SDA low (open drain, never drives high)
interface iic_slave_regs_if;
  logic iic_scl;
  logic iic_sda_i;
  logic iic_sda_oe;

  modport master (output iic_scl, output iic_sda_i, input iic_sda_oe);
  modport slave  (input iic_scl, input iic_sda_i, output iic_sda_oe);
endinterface

// File: rtl/iic_in_filter.sv
// Two-FF synchronizer followed by a glitch filter: dout only moves to a new
// level after FILTER_LEN consecutive synchronized samples of that level.
// Pad-to-dout latency is 2+FILTER_LEN clk. Resets to level 1 (idle bus).
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pad level
//   dout     : filtered level
module iic_in_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive samples that differ from the current output
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iic_slave_regs.sv
// I2C slave exposing a 256x8 register file with an auto-incrementing pointer.
// Write frame: ADDR(W), pointer, data... ; read frame (IIC_SLAVE_READ_EN):
// ADDR(R) then bytes from regfile[pointer]. Without IIC_SLAVE_READ_EN a read
// address is NACKed and only writes are supported.
//   clk, rst                 : system clock, synchronous active-high reset
//   bus                      : I2C pads (scl, sda level, sda pull-down enable)
//   reg_wr_en/addr/data      : one-clk strobe per accepted write byte
//   user_addr / user_rdata   : local read port, 1-clk latency
//   busy                     : high from address match until STOP / foreign START
module iic_slave_regs
  import iic_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  iic_slave_regs_if.slave   bus,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic [DATA_W-1:0] user_addr,
  output logic [DATA_W-1:0] user_rdata,
  output logic              busy
);

  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  iic_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .din(bus.iic_scl), .dout(scl_f)
  );
  iic_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .din(bus.iic_sda_i), .dout(sda_f)
  );

  // Previous filtered levels for edge / START / STOP detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  iic_state_e        state_q, state_n;
  logic [2:0]        bit_cnt_q, bit_cnt_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [DATA_W-1:0] ptr_q, ptr_n;
  logic              oe_q, oe_n;
  logic              busy_q, busy_n;
  logic              wr_en_q, wr_en_n;
  reg_wr_t           wr_q, wr_n;
  logic [DATA_W-1:0] regfile [REG_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] byte_in;
  logic              byte_done;
  logic              addr_ok;

  assign byte_in   = {shift_q[6:0], sda_f};
  assign byte_done = scl_rise & (bit_cnt_q == 3'd7);
`ifdef IIC_SLAVE_READ_EN
  assign addr_ok   = (byte_in[7:1] == SLAVE_ADDR);
`else
  assign addr_ok   = (byte_in[7:1] == SLAVE_ADDR) & ~byte_in[0];
`endif

`ifdef IIC_SLAVE_READ_EN
  logic              rw_q, rw_n;
  logic [DATA_W-1:0] tx_q, tx_n;
  logic [DATA_W-1:0] rd_cur, rd_nxt;
  assign rd_cur = regfile[ptr_q];
  assign rd_nxt = regfile[ptr_q + DATA_W'(1)];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next state; ACK states use oe_q to tell the drive fall from the release fall
  always_comb begin
    state_n = state_q;
    if (start_det) begin
      state_n = ST_ADDR;
    end else if (stop_det) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:      if (byte_done) state_n = addr_ok ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK: begin
          if (scl_fall && oe_q) begin
`ifdef IIC_SLAVE_READ_EN
            state_n = rw_q ? ST_RDATA : ST_SUB;
`else
            state_n = ST_SUB;
`endif
          end
        end
        ST_SUB:       if (byte_done) state_n = ST_SUB_ACK;
        ST_SUB_ACK:   if (scl_fall && oe_q) state_n = ST_WDATA;
        ST_WDATA:     if (byte_done) state_n = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall && oe_q) state_n = ST_WDATA;
`ifdef IIC_SLAVE_READ_EN
        ST_RDATA:     if (byte_done) state_n = ST_RDATA_ACK;
        ST_RDATA_ACK: if (scl_rise) state_n = (sda_f == ACK_LVL) ? ST_RDATA : ST_IDLE;
`endif
        default:      state_n = state_q;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    oe_n      = oe_q;
    busy_n    = busy_q;
    ptr_n     = ptr_q;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt_q;
    wr_en_n   = 1'b0;
    wr_n      = wr_q;
`ifdef IIC_SLAVE_READ_EN
    rw_n      = rw_q;
    tx_n      = tx_q;
`endif
    if (start_det) begin
      oe_n      = 1'b0;
      bit_cnt_n = '0;
    end else if (stop_det) begin
      oe_n      = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
    end else begin
      if (scl_rise) begin
        shift_n   = byte_in;
        bit_cnt_n = bit_cnt_q + 3'd1;
      end
      case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            busy_n = addr_ok;
`ifdef IIC_SLAVE_READ_EN
            rw_n   = byte_in[0];
`endif
          end
        end
        ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            oe_n = ~oe_q;
            if (oe_q) begin
              bit_cnt_n = '0;
              if (state_q == ST_WDATA_ACK) ptr_n = ptr_q + DATA_W'(1);
`ifdef IIC_SLAVE_READ_EN
              // Read frame: first data bit goes out on the same fall that ends ACK
              if (state_q == ST_ADDR_ACK && rw_q) begin
                tx_n = rd_cur;
                oe_n = ~rd_cur[7];
              end
`endif
            end
          end
        end
        ST_SUB:   if (byte_done) ptr_n = byte_in;
        ST_WDATA: begin
          if (byte_done) begin
            wr_en_n = 1'b1;
            wr_n    = '{addr: ptr_q, data: byte_in};
          end
        end
`ifdef IIC_SLAVE_READ_EN
        ST_RDATA: if (scl_fall) oe_n = ~tx_q[3'd7 - bit_cnt_q];
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            oe_n = 1'b0;
          end else if (scl_rise) begin
            ptr_n     = ptr_q + DATA_W'(1);
            bit_cnt_n = '0;
            if (sda_f == ACK_LVL) tx_n = rd_nxt;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_q      <= '0;
`ifdef IIC_SLAVE_READ_EN
      rw_q      <= 1'b0;
      tx_q      <= '0;
`endif
    end else begin
      oe_q      <= oe_n;
      busy_q    <= busy_n;
      ptr_q     <= ptr_n;
      shift_q   <= shift_n;
      bit_cnt_q <= bit_cnt_n;
      wr_en_q   <= wr_en_n;
      wr_q      <= wr_n;
`ifdef IIC_SLAVE_READ_EN
      rw_q      <= rw_n;
      tx_q      <= tx_n;
`endif
    end
  end

  // Register file; a same-cycle user read of the written address sees old data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_DEPTH); i++) regfile[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_en_n) regfile[wr_n.addr] <= wr_n.data;
      rdata_q <= regfile[user_addr];
    end
  end

  assign bus.iic_sda_oe = oe_q;
  assign reg_wr_en      = wr_en_q;
  assign reg_wr_addr    = wr_q.addr;
  assign reg_wr_data    = wr_q.data;
  assign user_rdata     = rdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bench for iic_slave_regs: bit-banged I2C master, table of write frames,
// plus hand sequences for repeated-START read, SDA glitch and mid-frame reset.
module tb_iic_slave_regs;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data, user_addr, user_rdata;
  logic       busy;

  always #5 clk = ~clk;

  iic_slave_regs_if bus ();
  assign bus.iic_scl   = m_scl;
  assign bus.iic_sda_i = m_sda & ~bus.iic_sda_oe;

  iic_slave_regs #(.SLAVE_ADDR(7'h5D), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .reg_wr_en(wr_en), .reg_wr_addr(wr_addr), .reg_wr_data(wr_data),
    .user_addr(user_addr), .user_rdata(user_rdata), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        ack_q [$];
  logic [15:0] wr_q  [$];
  logic [7:0]  rd_q  [$];
  logic [7:0]  mdl   [256];
  logic        oe_seen;
  logic        wr_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write strobe scoreboard and oe activity monitor
  always @(negedge clk) begin
    if (bus.iic_sda_oe === 1'b1) oe_seen = 1'b1;
    if (rst === 1'b0 && wr_en === 1'b1) begin
      if (wr_prev) check("wr_pulse_len", 32'(wr_prev), 32'd0);
      else if (wr_q.size() == 0) check("wr_unexpected", {24'd0, wr_addr}, 32'hFFFF_FFFF);
      else check("wr_strobe", {16'd0, wr_addr, wr_data}, {16'd0, wr_q.pop_front()});
    end
    wr_prev = (wr_en === 1'b1);
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic qwait(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait(2);
  endtask

  task automatic put_bit(input logic b, input bit glitch = 1'b0);
    m_sda = b; qwait();
    m_scl = 1'b1;
    if (glitch) begin
      repeat (Q / 2) @(negedge clk);
      m_sda = 1'b0;
      repeat (2) @(negedge clk);
      m_sda = 1'b1;
      repeat (2 * Q - Q / 2 - 2) @(negedge clk);
    end else begin
      qwait(2);
    end
    m_scl = 1'b0; qwait();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    b = bus.iic_sda_i;
    qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input int glitch_bit = -1);
    logic a, got;
    ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
    get_bit(a);
    got = ~a;
    check("ack", {31'd0, got}, {31'd0, ack_q.pop_front()});
  endtask

  task automatic recv_byte(input logic master_ack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    check("rdata", {24'd0, d}, {24'd0, rd_q.pop_front()});
    put_bit(~master_ack);
  endtask

  task automatic user_read(input logic [7:0] a);
    user_addr = a;
    repeat (2) @(negedge clk);
    check("user_rdata", {24'd0, user_rdata}, {24'd0, mdl[a]});
  endtask

  typedef struct {
    int              n;
    logic [3:0][7:0] b;
    logic [3:0]      ack;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3, input logic [3:0] ack);
    vec_t v;
    v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.ack = ack;
    return v;
  endfunction

  localparam int NVEC = 6;
  vec_t vecs [NVEC];
  logic [7:0] chk_addrs [9];

  initial begin
    logic [7:0] mptr, d;
    logic       b;

    vecs[0] = mk(3, 8'hBA, 8'h0D, 8'h47, 8'h00, 4'b0111);
    vecs[1] = mk(4, 8'hBA, 8'hFF, 8'h11, 8'h22, 4'b1111);
    vecs[2] = mk(1, 8'hB8, 8'h00, 8'h00, 8'h00, 4'b0000);
    vecs[3] = mk(4, 8'hBA, 8'h0A, 8'h77, 8'h88, 4'b1111);
    vecs[4] = mk(4, 8'hBA, 8'h20, 8'hA5, 8'h5A, 4'b1111);
    vecs[5] = mk(2, 8'hBA, 8'h30, 8'h00, 8'h00, 4'b0011);
    chk_addrs = '{8'h0D, 8'hFF, 8'h00, 8'h0A, 8'h0B, 8'h20, 8'h21, 8'h22, 8'h30};
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mptr = 8'h00;

    // Reset state
    m_scl = 1'b1; m_sda = 1'b1; user_addr = 8'h00; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_oe",      {31'd0, bus.iic_sda_oe}, 32'd0);
    check("rst_wr_en",   {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_rdata",   {24'd0, user_rdata}, 32'd0);

    // Table of write frames
    for (int v = 0; v < NVEC; v++) begin
      oe_seen = 1'b0;
      bus_start();
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i == 1 && vecs[v].ack[0]) mptr = vecs[v].b[1];
        if (i >= 2 && vecs[v].ack[0]) begin
          wr_q.push_back({mptr, vecs[v].b[i]});
          mdl[mptr] = vecs[v].b[i];
          mptr = mptr + 8'd1;
        end
        send_byte(vecs[v].b[i], vecs[v].ack[i]);
      end
      check("busy_open", {31'd0, busy}, {31'd0, vecs[v].ack[0]});
      check("oe_activity", {31'd0, oe_seen}, {31'd0, vecs[v].ack[0]});
      bus_stop();
      qwait();
      check("busy_stop", {31'd0, busy}, 32'd0);
    end

    for (int i = 0; i < 9; i++) user_read(chk_addrs[i]);

    // Pointer write, repeated START, read
    bus_start();
    send_byte(8'hBA, 1'b1);
    send_byte(8'h0A, 1'b1);
    bus_start();
`ifdef IIC_SLAVE_READ_EN
    send_byte(8'hBB, 1'b1);
    check("busy_read", {31'd0, busy}, 32'd1);
    rd_q.push_back(mdl[8'h0A]);
    rd_q.push_back(mdl[8'h0B]);
    recv_byte(1'b1);
    recv_byte(1'b0);
`else
    send_byte(8'hBB, 1'b0);
    check("busy_read_nack", {31'd0, busy}, 32'd0);
`endif
    bus_stop();
    qwait();
    check("busy_after_read", {31'd0, busy}, 32'd0);

    // 2-clk SDA glitch while SCL high inside a data byte
    bus_start();
    send_byte(8'hBA, 1'b1);
    send_byte(8'h50, 1'b1);
    wr_q.push_back({8'h50, 8'hFF});
    mdl[8'h50] = 8'hFF;
    send_byte(8'hFF, 1'b1, 7);
    bus_stop();
    user_read(8'h50);

    // Reset while the slave is driving ACK for the pointer byte
    bus_start();
    send_byte(8'hBA, 1'b1);
    d = 8'h60;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    check("ack_before_rst", {31'd0, bus.iic_sda_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_oe", {31'd0, bus.iic_sda_oe}, 32'd0);
    check("rst_busy_mid",   {31'd0, busy}, 32'd0);
    check("rst_wr_addr_mid", {24'd0, wr_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    oe_seen = 1'b0;
    get_bit(b);
    d = 8'h99;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    bus_stop();
    check("oe_after_rst", {31'd0, oe_seen}, 32'd0);
    user_read(8'h0D);

    // Recovery on the next START
    bus_start();
    send_byte(8'hBA, 1'b1);
    send_byte(8'h05, 1'b1);
    wr_q.push_back({8'h05, 8'h3C});
    mdl[8'h05] = 8'h3C;
    send_byte(8'h3C, 1'b1);
    bus_stop();
    user_read(8'h05);

    check("ack_q_empty", 32'(ack_q.size()), 32'd0);
    check("wr_q_empty",  32'(wr_q.size()), 32'd0);
    check("rd_q_empty",  32'(rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iic_slave_regs.md
IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h5D, 7-bit device address matched on the bus (write byte 8'hBA).
REQ-002 SHALL have parameter FILTER_LEN, default 3, the number of consecutive equal samples needed to accept a new SCL/SDA level.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock. Everything is sampled on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port iic_scl, input, 1 bit: bus clock, asynchronous to clk.
REQ-006 SHALL have port iic_sda_i, input, 1 bit: bus data level, asynchronous to clk.
REQ-007 SHALL have port iic_sda_oe, output, 1 bit: 1 pulls SDA low; the pad is open-drain and never driven high.
REQ-008 SHALL have ports reg_wr_en (output, 1 bit), reg_wr_addr (output, 8 bits) and reg_wr_data (output, 8 bits): a one-clk strobe plus its address and data for each accepted write byte.
REQ-009 SHALL have ports user_addr (input, 8 bits) and user_rdata (output, 8 bits): a local read port into the register file, registered with 1-clk latency.
REQ-010 SHALL have port busy, output, 1 bit: high from an address match until STOP or a non-matching repeated START.

Function
REQ-011 Input conditioning:
- iic_scl and iic_sda_i each pass through a 2-FF synchronizer, then a FILTER_LEN glitch filter.
- Filtered levels scl_f and sda_f SHALL change only after FILTER_LEN equal samples.
REQ-012 START SHALL be detected as sda_f falling while scl_f is high; STOP as sda_f rising while scl_f is high.
- START in any state moves to ADDR and clears the bit counter.
- STOP in any state moves to IDLE.
REQ-013 States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-014 Bit handling:
- Input bits SHALL be shifted MSB first on the scl_f rising edge.
- SDA SHALL be changed only on the clk after the scl_f falling edge, and held until the next scl_f falling edge.
REQ-015 ADDR, after 8 bits:
- Bits[7:1] == SLAVE_ADDR: go to ADDR_ACK, drive ACK (oe=1) for one SCL period, assert busy.
- Mismatch: release SDA and return to IDLE; no outputs change.
REQ-016 After ADDR_ACK:
- R/W=0: go to SUB. The received byte loads the 8-bit pointer; go to SUB_ACK (ACK), then WDATA.
- R/W=1: go to RDATA, transmitting regfile[pointer].
REQ-017 WDATA, after 8 bits:
- Write regfile[pointer].
- Pulse reg_wr_en for exactly 1 clk with reg_wr_addr = pointer and reg_wr_data = the byte.
- ACK, then increment the pointer modulo 256 (8'hFF wraps to 8'h00).
REQ-018 RDATA:
- Drive oe = ~bit, MSB first.
- In RDATA_ACK, release SDA and sample the master's ACK on scl_f rising.
- ACK (sda_f=0): increment the pointer modulo 256 and send the next byte.
- NACK: release SDA and wait for STOP or START; the pointer is still incremented.
REQ-019 A repeated START after SUB_ACK SHALL keep the pointer, so a write-pointer-then-read sequence works.
REQ-020 Register file: 256x8, reset to 8'h00. An I2C write and a user read of the same address in one clk returns the old data.
REQ-021 Total latency from a pad edge to the internal event SHALL be 2+FILTER_LEN clk. clk SHALL be at least 20x the SCL frequency.

Reset
REQ-022 With rst high, on the next clk edge:
- State IDLE, pointer 0, regfile cleared.
- iic_sda_oe=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, user_rdata=0, busy=0.
- Filters preset to level 1.
REQ-023 rst asserted mid-transfer SHALL release SDA immediately and ignore the rest of the frame until the next START.

Configuration
REQ-024 Macro IIC_SLAVE_READ_EN controls read support.
- Defined: RDATA and RDATA_ACK exist and reads work as above.
- Undefined: an address match with R/W=1 is NACKed (SDA released) and the block returns to IDLE with busy=0; only writes are supported.

Structure
REQ-025 Shared package iic_pkg SHALL hold the state enumeration, the ACK/NACK level constants and the default SLAVE_ADDR.
REQ-026 The synchronizer plus glitch filter SHALL be a sub-module iic_in_filter, instantiated once each for SCL and SDA.

Verification
REQ-027 Write 8'hBA, 8'h0D, 8'h47, STOP -> three ACKs, one reg_wr_en pulse with addr 8'h0D and data 8'h47; user_addr=8'h0D gives user_rdata=8'h47.
REQ-028 Write 8'hBA, 8'hFF, 8'h11, 8'h22 -> regfile[FF]=8'h11 and regfile[00]=8'h22 (pointer wrap).
REQ-029 Write 8'hB8 -> no ACK, iic_sda_oe stays 0, busy stays 0.
REQ-030 Write 8'hBA, 8'h0A, repeated START, 8'hBB, read 2 bytes ACK then NACK -> returns regfile[0A] and regfile[0B]; without IIC_SLAVE_READ_EN, 8'hBB is NACKed.
REQ-031 2-clk SDA glitch while SCL is high -> no START/STOP detected; rst mid-byte -> SDA released, no write strobe.
